// File: rtl/display_button_scanner.sv
// display_button_scanner: drives the load/shift clock of the display board's
// parallel-in/serial-out button chain, captures one word per scan period,
// inverts it (board buttons are active low) and debounces each bit.
//
// Handshake: scan_valid is a one-cycle strobe with no ready. raw, buttons and
// pressed hold new values in exactly the cycle scan_valid is high. raw and
// buttons then stay stable until the next strobe. pressed is zero whenever
// scan_valid is low.
`timescale 1ns/1ps
module display_button_scanner #(
  parameter int NBITS       = 16,
  parameter int CLK_DIV     = 25,
  parameter int SCAN_PERIOD = 50000,
  parameter int DEBOUNCE    = 4
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  output logic             SHIFT_CLKIN,
  output logic             SHIFT_LOAD,
  input  logic             SHIFT_OUT,
  output logic [NBITS-1:0] raw,
  output logic [NBITS-1:0] buttons,
  output logic [NBITS-1:0] pressed,
  output logic             scan_valid,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int TW = $clog2(SCAN_PERIOD);
  localparam int BW = $clog2(NBITS + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_PERIOD - 1);
  localparam logic [BW-1:0] BIT_ALL    = BW'(NBITS);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SETTLE   = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_SHIFT_HI = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [NBITS-1:0] cap_q, cap_d;
  logic [1:0]       sync_q;
  logic             shift_clkin_q, shift_clkin_d;
  logic             shift_load_q, shift_load_d;
  logic [NBITS-1:0] raw_q, raw_d;
  logic [NBITS-1:0] buttons_q, buttons_d;
  logic [NBITS-1:0] pressed_q, pressed_d;
  logic             scan_valid_q, scan_valid_d;
  logic [DW-1:0]    db_cnt_q [NBITS];
  logic [DW-1:0]    db_cnt_d [NBITS];

  logic timer_expire;
  logic phase_end;

  assign timer_expire = (timer_q == TIMER_LAST);
  assign phase_end    = (cnt_q == CNT_LAST);

  // Two-flop synchronizer for the asynchronous serial data from the board.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], SHIFT_OUT};
  end

  // State, counters, capture word, pin drivers and published outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      timer_q       <= TIMER_LAST;
      cap_q         <= '0;
      shift_clkin_q <= 1'b0;
      shift_load_q  <= 1'b1;
      raw_q         <= '0;
      buttons_q     <= '0;
      pressed_q     <= '0;
      scan_valid_q  <= 1'b0;
      for (int i = 0; i < NBITS; i++) db_cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      timer_q       <= timer_d;
      cap_q         <= cap_d;
      shift_clkin_q <= shift_clkin_d;
      shift_load_q  <= shift_load_d;
      raw_q         <= raw_d;
      buttons_q     <= buttons_d;
      pressed_q     <= pressed_d;
      scan_valid_q  <= scan_valid_d;
      for (int i = 0; i < NBITS; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Scan sequencer: phase timing, MSB-first sampling, pin levels from next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cap_d   = cap_q;
    timer_d = timer_expire ? '0 : timer_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (timer_expire) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_LOAD: begin
        if (phase_end) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_SETTLE: begin
        if (phase_end) begin
          state_d = S_SHIFT_LO;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_SHIFT_LO: begin
        if (phase_end) begin
          // Latest point before the rising edge: data has had the longest time to settle.
          cap_d   = {cap_q[NBITS-2:0], sync_q[1]};
          bit_d   = bit_q + 1'b1;
          state_d = S_SHIFT_HI;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_SHIFT_HI: begin
        if (phase_end) begin
          state_d = (bit_q == BIT_ALL) ? S_DONE : S_SHIFT_LO;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    shift_load_d  = (state_d != S_LOAD);
    shift_clkin_d = (state_d == S_SHIFT_HI);
  end

  // Per-bit debounce and edge detect, evaluated once per completed scan.
  always_comb begin
    raw_d        = raw_q;
    buttons_d    = buttons_q;
    pressed_d    = '0;
    scan_valid_d = 1'b0;
    for (int i = 0; i < NBITS; i++) db_cnt_d[i] = db_cnt_q[i];
    if (state_q == S_DONE) begin
      raw_d        = ~cap_q;
      scan_valid_d = 1'b1;
      for (int i = 0; i < NBITS; i++) begin
        if (raw_d[i] != buttons_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            buttons_d[i] = ~buttons_q[i];
            db_cnt_d[i]  = '0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_d[i] = '0;
        end
      end
      pressed_d = buttons_d & ~buttons_q;
    end
  end

  assign SHIFT_CLKIN = shift_clkin_q;
  assign SHIFT_LOAD  = shift_load_q;
  assign raw         = raw_q;
  assign buttons     = buttons_q;
  assign pressed     = pressed_q;
  assign scan_valid  = scan_valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_display_button_scanner.sv
// Bench for display_button_scanner: a board model serves the button word on the
// serial chain, a reference model predicts each scan's outputs into a queue, and
// a monitor pops and compares on every scan_valid.
`timescale 1ns/1ps
module tb_display_button_scanner;

  localparam int NB   = 16;
  localparam int CD   = 4;
  localparam int SP   = 200;
  localparam int DB   = 3;
  localparam int SLEN = 2 * CD + 2 * CD * NB + 1;

  logic          CLOCK_50;
  logic          RESET_N;
  logic          SHIFT_CLKIN;
  logic          SHIFT_LOAD;
  logic          shift_out;
  logic [NB-1:0] raw;
  logic [NB-1:0] buttons;
  logic [NB-1:0] pressed;
  logic          scan_valid;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [47:0]   exp_q[$];
  logic [NB-1:0] board_word = 16'hFFFF;

  display_button_scanner #(
    .NBITS(NB), .CLK_DIV(CD), .SCAN_PERIOD(SP), .DEBOUNCE(DB)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .SHIFT_CLKIN(SHIFT_CLKIN),
    .SHIFT_LOAD (SHIFT_LOAD),
    .SHIFT_OUT  (shift_out),
    .raw        (raw),
    .buttons    (buttons),
    .pressed    (pressed),
    .scan_valid (scan_valid),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc;
  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- board model (74HC165-like chain) ----------------
  logic [NB-1:0] sreg;
  int            dly;
  initial shift_out = 1'b1;
  always @(posedge SHIFT_CLKIN or negedge SHIFT_LOAD) begin
    if (!SHIFT_LOAD) begin
      sreg      = board_word;
      shift_out = board_word[NB-1];
    end else begin
      sreg = {sreg[NB-2:0], 1'b1};
      dly  = $urandom_range(1, 9);
      #(dly);
      shift_out = sreg[NB-1];
    end
  end

  // ---------------- reference model: one prediction per load ----------------
  logic [NB-1:0] m_btn = '0;
  int            m_streak[NB] = '{default: 0};
  logic [NB-1:0] m_raw, m_old;
  always @(negedge SHIFT_LOAD or negedge RESET_N) begin
    if (!RESET_N) begin
      exp_q.delete();
      m_btn = '0;
      for (int i = 0; i < NB; i++) m_streak[i] = 0;
    end else begin
      m_raw = ~board_word;
      m_old = m_btn;
      for (int i = 0; i < NB; i++) begin
        if (m_raw[i] == m_btn[i]) m_streak[i] = 0;
        else begin
          m_streak[i] = m_streak[i] + 1;
          if (m_streak[i] == DB) begin
            m_btn[i]    = m_raw[i];
            m_streak[i] = 0;
          end
        end
      end
      exp_q.push_back({m_raw, m_btn, m_btn & ~m_old});
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic        exp_sv;
  logic [47:0] e;
  always @(negedge CLOCK_50) begin
    if (RESET_N) begin
      exp_sv = (cyc >= SLEN + 1) && (((cyc - (SLEN + 1)) % SP) == 0);
      chk("scan_valid_timing", 16'(scan_valid), 16'(exp_sv));
      if (scan_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: scan_valid with no expected entry (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_raw", raw, e[47:32]);
          chk("sb_buttons", buttons, e[31:16]);
          chk("sb_pressed", pressed, e[15:0]);
        end
      end else begin
        chk("pressed_idle", pressed, 16'h0000);
      end
    end
  end

  // ---------------- waveform monitor ----------------
  int   load_run, hi_run, lo_run, pulses;
  logic prev_load, prev_clk;
  always @(negedge CLOCK_50) begin
    if (!RESET_N) begin
      load_run = 0; hi_run = 0; lo_run = 0; pulses = 0;
      prev_load = 1'b1; prev_clk = 1'b0;
    end else begin
      chk("clk_load_same_cycle", 16'((SHIFT_LOAD != prev_load) && (SHIFT_CLKIN != prev_clk)), 16'h0);
      chk("clk_while_load", 16'(SHIFT_CLKIN && !SHIFT_LOAD), 16'h0);
      if (!SHIFT_LOAD) load_run++;
      if (SHIFT_LOAD && !prev_load) begin
        chk("load_low_len", 16'(load_run), 16'(CD));
        load_run = 0;
        pulses   = 0;
      end
      if (SHIFT_CLKIN) begin
        if (!prev_clk) begin
          if (pulses > 0) chk("clk_low_len", 16'(lo_run), 16'(CD));
          hi_run = 1;
        end else hi_run++;
      end else begin
        if (prev_clk) begin
          chk("clk_high_len", 16'(hi_run), 16'(CD));
          pulses++;
          lo_run = 1;
        end else lo_run++;
      end
      if (scan_valid) chk("clk_pulse_count", 16'(pulses), 16'(NB));
      prev_load = SHIFT_LOAD;
      prev_clk  = SHIFT_CLKIN;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_scan(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * SP; i++) begin
      @(negedge CLOCK_50);
      if (scan_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: no scan_valid within %0d cycles", 2 * SP);
    end
  endtask

  task automatic scan_chk(input logic [NB-1:0] r, input logic [NB-1:0] b, input logic [NB-1:0] p);
    logic ok;
    wait_scan(ok);
    if (ok) begin
      chk("dir_raw", raw, r);
      chk("dir_buttons", buttons, b);
      chk("dir_pressed", pressed, p);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_clkin"}, 16'(SHIFT_CLKIN), 16'h0);
    chk({tag, "_load"}, 16'(SHIFT_LOAD), 16'h1);
    chk({tag, "_raw"}, raw, 16'h0);
    chk({tag, "_buttons"}, buttons, 16'h0);
    chk({tag, "_pressed"}, pressed, 16'h0);
    chk({tag, "_scan_valid"}, 16'(scan_valid), 16'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   rises;
    logic prev_c;
    logic hit;
    logic ok;
    int   r;

    RESET_N    = 1'b0;
    board_word = 16'hFFFF;
    repeat (5) @(negedge CLOCK_50);
    check_reset_outputs("reset");
    RESET_N = 1'b1;

    // Idle board: nothing pressed
    scan_chk(16'h0000, 16'h0000, 16'h0000);
    scan_chk(16'h0000, 16'h0000, 16'h0000);

    // Bit order: board bits 15 and 0 low
    board_word = 16'h7FFE;
    scan_chk(16'h8001, 16'h0000, 16'h0000);
    board_word = 16'hFFFF;
    scan_chk(16'h0000, 16'h0000, 16'h0000);

    // Press bit 3: flips on the third agreeing scan
    board_word = 16'hFFF7;
    scan_chk(16'h0008, 16'h0000, 16'h0000);
    scan_chk(16'h0008, 16'h0000, 16'h0000);
    scan_chk(16'h0008, 16'h0008, 16'h0008);

    // Release bit 3
    board_word = 16'hFFFF;
    scan_chk(16'h0000, 16'h0008, 16'h0000);
    scan_chk(16'h0000, 16'h0008, 16'h0000);
    scan_chk(16'h0000, 16'h0000, 16'h0000);

    // Bounce 1,0,1,0 never sets bit 3
    for (int k = 0; k < 4; k++) begin
      board_word = (k % 2 == 0) ? 16'hFFF7 : 16'hFFFF;
      scan_chk((k % 2 == 0) ? 16'h0008 : 16'h0000, 16'h0000, 16'h0000);
    end

    // Press again so outputs are non-zero before the mid-scan reset
    board_word = 16'hFFF7;
    scan_chk(16'h0008, 16'h0000, 16'h0000);
    scan_chk(16'h0008, 16'h0000, 16'h0000);
    scan_chk(16'h0008, 16'h0008, 16'h0008);

    // Reset during the eighth SHIFT_HI phase
    rises  = 0;
    prev_c = 1'b0;
    hit    = 1'b0;
    for (int i = 0; i < 2 * SP && !hit; i++) begin
      @(negedge CLOCK_50);
      if (SHIFT_CLKIN && !prev_c) rises++;
      prev_c = SHIFT_CLKIN;
      if (rises == 8) hit = 1'b1;
    end
    chk("reach_bit7_shift_hi", 16'(hit), 16'h1);
    #1 RESET_N = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (5) begin
      @(negedge CLOCK_50);
      chk("midreset_no_valid", 16'(scan_valid), 16'h0);
    end
    RESET_N = 1'b1;
    scan_chk(16'h0008, 16'h0000, 16'h0000);

    // Randomised board words, checked by the scoreboard
    for (int k = 0; k < 50; k++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      board_word = 16'($urandom);
      else if (r == 1) board_word[$urandom_range(0, NB - 1)] = ~board_word[$urandom_range(0, NB - 1)];
      wait_scan(ok);
    end

    repeat (3) @(negedge CLOCK_50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_button_scanner.md
# display_button_scanner

Reads the Cambridge display board's button shift register, the parallel-in/serial-out chain behind SHIFT_CLKIN, SHIFT_LOAD and SHIFT_OUT. It generates the load and shift clock, captures a fixed-length word at a regular scan rate and debounces each bit. It presents a clean, active-high button vector to the rest of the FPGA design, beside the dial and LCD logic in the board top level.

## Interface
Parameters:
- NBITS, 16: length of the shift-register chain in bits.
- CLK_DIV, 25: SHIFT_CLKIN half-period in CLOCK_50 cycles. Minimum 4. The default gives 1 MHz.
- SCAN_PERIOD, 50000: CLOCK_50 cycles between scan starts. The default gives 1 kHz. Must exceed the scan length, 2·CLK_DIV·(NBITS+1)+1.
- DEBOUNCE, 4: number of consecutive scans that must disagree with the debounced state before a bit flips. Minimum 1.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- RESET_N  in  1  asynchronous, active-low reset.
- SHIFT_CLKIN  out  1  shift clock to the board; the register shifts on its rising edge.
- SHIFT_LOAD  out  1  parallel load, active low; high means shift mode.
- SHIFT_OUT  in  1  serial data from the board; asynchronous to CLOCK_50.
- raw  out  NBITS  inverted, undebounced word from the last completed scan.
- buttons  out  NBITS  debounced state; 1 = pressed.
- pressed  out  NBITS  per-bit 0→1 transitions of buttons; valid only while scan_valid is high.
- scan_valid  out  1  one-cycle pulse when raw, buttons and pressed hold new values.

## Operation
- SHIFT_OUT passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- FSM states: IDLE → LOAD → SETTLE → SHIFT_LO ⇄ SHIFT_HI → DONE → IDLE.
  - IDLE: SHIFT_LOAD=1, SHIFT_CLKIN=0. Wait for the scan timer to expire.
  - LOAD: SHIFT_LOAD=0 for CLK_DIV cycles.
  - SETTLE: SHIFT_LOAD=1, SHIFT_CLKIN=0 for CLK_DIV cycles.
  - SHIFT_LO: SHIFT_CLKIN=0 for CLK_DIV cycles. On the last cycle, sample the synchronized bit into the capture register, MSB-first: the first sample ends in bit NBITS-1.
  - SHIFT_HI: SHIFT_CLKIN=1 for CLK_DIV cycles. After NBITS samples, go to DONE. Otherwise return to SHIFT_LO.
  - DONE: 1 cycle. Load raw with the inverted capture word (board buttons are active low), update the debouncers and pulse scan_valid.
- Scan timer: modulo-SCAN_PERIOD counter, free-running. It restarts a scan each time it wraps. The first scan starts on the first clock edge after RESET_N deasserts. A timer expiry outside IDLE is dropped (cannot occur with legal parameters).
- Debounce, per bit, evaluated only in DONE:
  - If the new raw bit ≠ buttons bit, increment that bit's counter.
  - When the counter reaches DEBOUNCE, flip the buttons bit and clear the counter.
  - If the new raw bit = buttons bit, clear the counter.
- pressed = new buttons & ~old buttons, registered together with buttons. It is zero in every cycle where scan_valid=0.
- Counter widths are sized by $clog2 of each parameter; they must not wrap early.

## Timing
- Reset values:
  - Outputs: SHIFT_CLKIN=0, SHIFT_LOAD=1, raw=0, buttons=0, pressed=0, scan_valid=0.
  - Internal: FSM in IDLE with the timer at expiry; all debounce counters 0; synchronizer 0.
- Scan length from leaving IDLE to scan_valid is 2·CLK_DIV + 2·CLK_DIV·NBITS + 1 cycles.
- scan_valid is registered. It is high in the cycle after DONE, together with the new outputs.
- Each sample is taken ≥ CLK_DIV−2 cycles after the previous rising edge of SHIFT_CLKIN, which is ≥ 2 cycles of data settling plus synchronizer delay.
- SHIFT_LOAD and SHIFT_CLKIN are driven directly from flops (glitch-free). They never toggle in the same cycle.
- Reset asserted mid-scan: all outputs return to their reset values immediately. The partial capture is discarded. A fresh scan begins after release.

## Test plan
Parameters for all tests: NBITS=16, CLK_DIV=4, SCAN_PERIOD=200, DEBOUNCE=3. Scan length = 137.
- Waveform: a board model returns 16'hFFFF. Check that SHIFT_LOAD is low for exactly 4 cycles, that 16 SHIFT_CLKIN pulses follow, each 4 high / 4 low, that scan_valid pulses 138 cycles after reset release, then every 200 cycles, and that raw=0.
- Bit order: the model holds 16'h7FFE (buttons 15 and 0 pressed). Check raw=16'h8001 on the first scan_valid.
- Debounce: press bit 3. buttons[3] must stay 0 for two scans and go to 1 on the third scan_valid, with pressed=16'h0008 on that pulse only. A bounce pattern of 1,0,1,0 must never set buttons[3].
- Release: after the press, release bit 3. buttons[3] returns to 0 on the third scan_valid, and pressed stays 0.
- Reset mid-scan: assert RESET_N low during SHIFT_HI of bit 7. Check that the outputs return to their reset values asynchronously and that no scan_valid appears. After release, a full scan completes in 138 cycles with the correct raw.
- Async input: toggle SHIFT_OUT at random sub-cycle offsets only during the SHIFT_HI phase. Captured words must match the model exactly over 50 scans.
